// File: rtl/dmac_pkg.sv
// Shared definitions for the DMAC burst master: FSM state encoding and
// byte-shift / boundary helpers derived from the data and boundary widths.
package dmac_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WADDR,
    S_WDATA,
    S_WRESP,
    S_RADDR,
    S_RDATA
  } state_t;

  localparam int DEF_W_D          = 32;
  localparam int DEF_W_BOUNDARY_A = 12;
  localparam int BYTE_SHIFT       = $clog2(DEF_W_D / 8);
  localparam int BOUNDARY_BYTES   = 1 << DEF_W_BOUNDARY_A;

  function automatic int byte_shift(input int w_d);
    return $clog2(w_d / 8);
  endfunction

  function automatic int boundary_bytes(input int w_boundary_a);
    return 1 << w_boundary_a;
  endfunction

endpackage

// File: rtl/dmac_burst_len_calc.sv
// Combinational burst sizing: min(remaining words, MAX_BURST_LEN, words left before the boundary).
// Zero latency, no handshake; the caller registers the result.
module dmac_burst_len_calc
  import dmac_pkg::*;
#(
  parameter int W_D           = DEF_W_D,
  parameter int W_BOUNDARY_A  = DEF_W_BOUNDARY_A,
  parameter int W_BLEN        = 8,
  parameter int MAX_BURST_LEN = 256,
  parameter int W_SIZE        = 32
) (
  input  logic [W_SIZE-1:0]       remaining,
  input  logic [W_BOUNDARY_A-1:0] addr_low,
  output logic [W_BLEN:0]         blen
);

  localparam int SHIFT = byte_shift(W_D);
  localparam int WC    = ((W_SIZE > W_BOUNDARY_A) ? W_SIZE : W_BOUNDARY_A) + 1;

  logic [W_BOUNDARY_A:0] bnd_bytes;
  logic [WC-1:0]         rem_w, max_w, bnd_w, min_a, min_b;

  always_comb begin
    // addr_low is word aligned, so at least one word always fits before the boundary
    bnd_bytes = {1'b1, {W_BOUNDARY_A{1'b0}}} - {1'b0, addr_low};
    rem_w     = WC'(remaining);
    max_w     = WC'(MAX_BURST_LEN);
    bnd_w     = WC'(bnd_bytes >> SHIFT);
    min_a     = (rem_w < max_w) ? rem_w : max_w;
    min_b     = (min_a < bnd_w) ? min_a : bnd_w;
    blen      = (W_BLEN + 1)'(min_b);
  end

endmodule

// File: rtl/dmac_burst_master.sv
// AXI-style DMA burst master: splits one request into boundary-safe bursts, one outstanding at a time.
// Address phase registered; data is a combinational pass-through, so backpressure stalls both sides losslessly.
module dmac_burst_master
  import dmac_pkg::*;
#(
  parameter int W_D           = DEF_W_D,
  parameter int W_EXT_A       = 32,
  parameter int W_BOUNDARY_A  = DEF_W_BOUNDARY_A,
  parameter int W_BLEN        = 8,
  parameter int MAX_BURST_LEN = 256,
  parameter int W_SIZE        = 32
) (
  input  logic               ACLK,
  input  logic               ARESETN,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [W_EXT_A-1:0] req_addr,
  input  logic [W_SIZE-1:0]  req_size,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               awvalid,
  output logic [W_EXT_A-1:0] awaddr,
  output logic [W_BLEN-1:0]  awlen,
  input  logic               awready,
  output logic               wvalid,
  output logic [W_D-1:0]     wdata,
  output logic               wlast,
  input  logic               wready,
  input  logic               bvalid,
  output logic               bready,
  output logic               arvalid,
  output logic [W_EXT_A-1:0] araddr,
  output logic [W_BLEN-1:0]  arlen,
  input  logic               arready,
  input  logic               rvalid,
  input  logic [W_D-1:0]     rdata,
  input  logic               rlast,
  output logic               rready,
  input  logic               src_valid,
  input  logic [W_D-1:0]     src_data,
  output logic               src_ready,
  output logic               dst_valid,
  output logic [W_D-1:0]     dst_data,
  input  logic               dst_ready
);

  localparam int SHIFT = byte_shift(W_D);
  localparam logic [W_EXT_A-1:0] ALIGN_MASK = ~((W_EXT_A'(1) << SHIFT) - W_EXT_A'(1));
  localparam logic [W_BLEN:0]    ONE        = {{W_BLEN{1'b0}}, 1'b1};

  state_t                  state;
  logic [W_EXT_A-1:0]      addr_q, req_addr_al;
  logic [W_SIZE-1:0]       rem_q, calc_rem;
  logic [W_BOUNDARY_A-1:0] calc_low;
  logic [W_BLEN:0]         blen_q, calc_blen;
  logic [W_BLEN-1:0]       len_q, len_n, beat_q;
  logic                    last_beat;

  // In IDLE the calculator sizes the first burst straight from the request
  assign req_addr_al = req_addr & ALIGN_MASK;
  assign calc_rem    = (state == S_IDLE) ? req_size : rem_q;
  assign calc_low    = (state == S_IDLE) ? req_addr_al[W_BOUNDARY_A-1:0] : addr_q[W_BOUNDARY_A-1:0];
  assign len_n       = W_BLEN'(calc_blen - ONE);
  assign last_beat   = (beat_q == len_q);

  dmac_burst_len_calc #(
    .W_D(W_D), .W_BOUNDARY_A(W_BOUNDARY_A), .W_BLEN(W_BLEN),
    .MAX_BURST_LEN(MAX_BURST_LEN), .W_SIZE(W_SIZE)
  ) u_len_calc (
    .remaining(calc_rem),
    .addr_low (calc_low),
    .blen     (calc_blen)
  );

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      blen_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      awvalid <= 1'b0;
      arvalid <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (req_valid) begin
          err    <= 1'b0;
          addr_q <= req_addr_al;
          rem_q  <= req_size;
          if (req_size == '0) begin
            done <= 1'b1;
          end else begin
            blen_q <= calc_blen;
            len_q  <= len_n;
            if (req_write) begin
              state   <= S_WADDR;
              awvalid <= 1'b1;
            end else begin
              state   <= S_RADDR;
              arvalid <= 1'b1;
            end
          end
        end
        S_WADDR, S_RADDR: if ((awvalid && awready) || (arvalid && arready)) begin
          awvalid <= 1'b0;
          arvalid <= 1'b0;
          addr_q  <= addr_q + (W_EXT_A'(blen_q) << SHIFT);
          rem_q   <= rem_q - W_SIZE'(blen_q);
          beat_q  <= '0;
          state   <= (state == S_WADDR) ? S_WDATA : S_RDATA;
        end
        S_WDATA: if (src_valid && wready) begin
          if (last_beat) state <= S_WRESP;
          else           beat_q <= beat_q + W_BLEN'(1);
        end
        S_WRESP: if (bvalid) begin
          if (rem_q == '0) begin
            done  <= 1'b1;
            state <= S_IDLE;
          end else begin
            blen_q  <= calc_blen;
            len_q   <= len_n;
            awvalid <= 1'b1;
            state   <= S_WADDR;
          end
        end
        S_RDATA: if (rvalid && dst_ready) begin
          // beat count closes the burst; rlast is only cross-checked
          if (rlast != last_beat) err <= 1'b1;
          if (!last_beat) begin
            beat_q <= beat_q + W_BLEN'(1);
          end else if (rem_q == '0) begin
            done  <= 1'b1;
            state <= S_IDLE;
          end else begin
            blen_q  <= calc_blen;
            len_q   <= len_n;
            arvalid <= 1'b1;
            state   <= S_RADDR;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    wvalid    = 1'b0;
    wdata     = '0;
    wlast     = 1'b0;
    src_ready = 1'b0;
    dst_valid = 1'b0;
    dst_data  = '0;
    rready    = 1'b0;
    if (state == S_WDATA) begin
      wvalid    = src_valid;
      wdata     = src_data;
      wlast     = last_beat;
      src_ready = wready;
    end
    if (state == S_RDATA) begin
      dst_valid = rvalid;
      dst_data  = rdata;
      rready    = dst_ready;
    end
  end

  assign awaddr    = addr_q;
  assign araddr    = addr_q;
  assign awlen     = len_q;
  assign arlen     = len_q;
  assign bready    = (state == S_WRESP);
  assign busy      = (state != S_IDLE);
  assign req_ready = (state == S_IDLE);

endmodule
